// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers used by the inverse round datapath.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1b;

    typedef logic [7:0]  aes_byte_t;
    typedef logic [31:0] aes_col_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } imc_state_e;

    localparam aes_byte_t INV_MC_E = 8'h0e;
    localparam aes_byte_t INV_MC_B = 8'h0b;
    localparam aes_byte_t INV_MC_D = 8'h0d;
    localparam aes_byte_t INV_MC_9 = 8'h09;

    function automatic aes_byte_t xtime(input aes_byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
    endfunction

    // Shift-and-add multiply; with constant k this folds down to an xtime chain plus XORs.
    function automatic aes_byte_t gf_mul(input aes_byte_t a, input aes_byte_t k);
        aes_byte_t acc;
        aes_byte_t p;
        acc = '0;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/inv_mix_column_word.sv
// Combinational InvMixColumns of one 32-bit column; row 0 is the most significant byte.
module inv_mix_column_word
    import aes_pkg::*;
(
    input  aes_col_t i_col,
    output aes_col_t o_col
);

    aes_byte_t w_a [4];

    assign w_a[0] = i_col[31:24];
    assign w_a[1] = i_col[23:16];
    assign w_a[2] = i_col[15:8];
    assign w_a[3] = i_col[7:0];

    for (genvar r = 0; r < 4; r++) begin : g_row
        assign o_col[31-8*r -: 8] = gf_mul(w_a[r],         INV_MC_E)
                                  ^ gf_mul(w_a[(r+1) % 4], INV_MC_B)
                                  ^ gf_mul(w_a[(r+2) % 4], INV_MC_D)
                                  ^ gf_mul(w_a[(r+3) % 4], INV_MC_9);
    end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative InvMixColumns: accepts a 128-bit state, transforms COLS_PER_CYCLE columns per cycle,
// then holds the result until the consumer takes it.
//   state | meaning
//   IDLE  | waiting for a block, in_ready=1
//   BUSY  | transforming columns of the work register
//   DONE  | result on state_out, out_valid=1 until out_ready
module inv_mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
        $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // With 4 columns per cycle the step wraps to 0, which keeps the counter parked at column 0.
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] COL_LAST = 2'(4 - COLS_PER_CYCLE);

    imc_state_e   r_state;
    imc_state_e   w_next;
    logic [1:0]   r_col;
    logic [127:0] r_work;
    logic [127:0] w_work_nxt;
    logic         w_accept;

    logic [1:0]   w_idx     [COLS_PER_CYCLE];
    aes_col_t     w_col_in  [COLS_PER_CYCLE];
    aes_col_t     w_col_out [COLS_PER_CYCLE];

    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
        assign w_idx[k]    = r_col + 2'(k);
        assign w_col_in[k] = r_work[127 - 32*w_idx[k] -: 32];

        inv_mix_column_word u_word (
            .i_col (w_col_in[k]),
            .o_col (w_col_out[k])
        );
    end

    always_comb begin
        w_work_nxt = r_work;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            w_work_nxt[127 - 32*w_idx[k] -: 32] = w_col_out[k];
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = ST_BUSY;
            end
            ST_BUSY: begin
                if (r_col == COL_LAST) w_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    in_ready = 1'b1;
                    w_next   = in_valid ? ST_BUSY : ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_accept  = in_valid && in_ready;
    assign state_out = r_work;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_col   <= 2'd0;
            r_work  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_work <= state_in;
                r_col  <= 2'd0;
            end else if (r_state == ST_BUSY) begin
                r_work <= w_work_nxt;
                r_col  <= r_col + COL_STEP;
            end
        end
    end

endmodule

// File: doc/inv_mix_columns_seq.md
# inv_mix_columns_seq

Iterative AES-128 InvMixColumns unit for the decryption datapath. It accepts one 128-bit state over a valid/ready handshake and multiplies each 32-bit column by the inverse circulant matrix {0e,0b,0d,09} over GF(2^8), processing `COLS_PER_CYCLE` columns per clock. It then holds the result on a valid/ready output until a consumer accepts it. It sits between InvShiftRows/InvSubBytes and AddRoundKey in the inverse round, and it is the exact inverse of the existing forward MixColumns byte mapping.

## Interface
- `COLS_PER_CYCLE`, default 1: number of columns transformed per busy cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset is asynchronous and active-low.
- `in_valid` input 1: `state_in` holds a block to transform.
- `in_ready` output 1: the block can accept a new state this cycle.
- `state_in` input 128: column-major state. Bits [127:120] are byte a0 (row0,col0), and column c is bytes a(4c)..a(4c+3).
- `out_valid` output 1: `state_out` holds a completed result.
- `out_ready` input 1: the consumer accepts `state_out` this cycle.
- `state_out` output 128: result, using the same byte ordering as `state_in`.

## Operation
- FSM with three states:
  - **IDLE**: `in_ready`=1. On `in_valid`, load `state_in` into the work register, clear the column counter and go to BUSY.
  - **BUSY**: `in_ready`=0. Each cycle, replace columns col..col+COLS_PER_CYCLE-1 of the work register with their inverse-mixed values, then advance col by COLS_PER_CYCLE. On the cycle that processes column 3, go to DONE.
  - **DONE**: `out_valid`=1 and `state_out` = work register, held stable until `out_ready`.
    - `out_ready` and `in_valid` together: accept the new block in the same cycle and go to BUSY (back-to-back).
    - `out_ready` only: go to IDLE.
- `in_ready` = (IDLE) or (DONE and `out_ready`).
- Per output byte of a column: b_r = 0e·a_r ^ 0b·a_(r+1) ^ 0d·a_(r+2) ^ 09·a_(r+3), with indices taken mod 4 within the column.
- Multiplication is GF(2^8) mod x^8+x^4+x^3+x+1. It is built from xtime chains (×2 = shift left, then conditional ^0x1b), and all arithmetic is 8-bit XOR with no carries.
- `state_in` is sampled only on the accepting edge. Later changes to it do not affect the block in flight.
- Column counter width is 2 bits, and it wraps only via reload on accept.

## Timing
- Reset values: FSM = IDLE, `in_ready`=1, `out_valid`=0, `state_out`=128'h0, work register 0, counter 0.
- Latency: `out_valid` rises 4/COLS_PER_CYCLE clock edges after the accepting edge. That is 4, 2 or 1 cycles after the accept.
- Throughput with `out_ready` held high: one block every 4/COLS_PER_CYCLE + 1 cycles (the DONE cycle overlaps the next accept).
- Output stall: while DONE and `out_ready`=0, `state_out` and `out_valid` stay constant and `in_ready`=0.
- Reset mid-operation: the asynchronous `rst_n` assertion immediately forces the reset values, and the in-flight block is discarded. The first accept can occur on the first rising edge after deassertion.
- `in_valid` is ignored in BUSY. No blocks are dropped, because `in_ready`=0 then.

## Structure
- Shared package `aes_pkg`:
  - `AES_POLY` = 8'h1b
  - column/byte typedefs (`aes_byte_t` [7:0], `aes_col_t` [31:0])
  - an `xtime` function
  - inverse coefficients `INV_MC_E/B/D/9`
- Sub-module `inv_mix_column_word`: a purely combinational 32-bit column in, 32-bit column out. It is instantiated COLS_PER_CYCLE times and muxed by the column counter.
- The top level holds the FSM, counter, work register and handshake.

## Test plan
- **FIPS column vectors.** Input `state_in` = 8e4da1bc_9fdc589d_01010101_c6c6c6c6. Required output after 4 cycles: `state_out` = db135345_f20a225c_01010101_c6c6c6c6.
- **Round-trip.** Feed 200 random states through the forward MixColumns, then through this block. The output must equal the original input, checked for every `COLS_PER_CYCLE` ∈ {1,2,4}. Also check latency = 4, 2 and 1 cycles respectively.
- **Output backpressure.** Hold `out_ready`=0 for 10 cycles after `out_valid`. `state_out` must stay stable, `in_ready`=0, and `in_valid` pulses must be ignored. Release `out_ready`: the next block is accepted in that same cycle.
- **Back-to-back.** Hold `in_valid`=1 and `out_ready`=1 with 3 distinct blocks. With COLS_PER_CYCLE=1, outputs appear at 5-cycle spacing in order and all are correct.
- **Reset mid-BUSY.** Assert `rst_n`=0 two cycles after an accept. `out_valid`=0, `state_out`=0 and `in_ready`=1 immediately, with no spurious output after release. A fresh block then completes correctly.
- **All-zero and all-ff states.** Input 00…00 → output 00…00. Input ff…ff → output ff…ff, because 0e^0b^0d^09 = 01.
